// File: rtl/rob_pkg.sv
// Shared types and constants for the reorder buffer and its lookup helper.
package rob_pkg;

    localparam int ROB_WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        TYPE_REG    = 2'b00,
        TYPE_STORE  = 2'b01,
        TYPE_BRANCH = 2'b10
    } rob_type_e;

    typedef struct packed {
        logic        busy;
        logic        done;
        rob_type_e   itype;
        logic [4:0]  rd;
        logic        pred_taken;
        logic [31:0] alt_pc;
        logic [31:0] val;
    } rob_entry_t;

endpackage

// File: rtl/rob_lookup.sv
// Operand tag lookup: reports readiness and value, bypassing live write-back data.
module rob_lookup
    import rob_pkg::*;
#(
    parameter int ROB_WIDTH = ROB_WIDTH_DEFAULT
) (
    input  logic [ROB_WIDTH-1:0]              tag,
    input  logic [(1<<ROB_WIDTH)-1:0]         done_vec,
    input  logic [(1<<ROB_WIDTH)-1:0][31:0]   val_vec,
    input  logic                              alu_flag,
    input  logic [31:0]                       alu_val,
    input  logic [ROB_WIDTH-1:0]              alu_dest,
    input  logic                              lsb_flag,
    input  logic [31:0]                       lsb_val,
    input  logic [ROB_WIDTH-1:0]              lsb_dest,
    output logic                              ready,
    output logic [31:0]                       val
);

    logic alu_hit;
    logic lsb_hit;

    always_comb begin
        alu_hit = alu_flag && (alu_dest == tag);
        lsb_hit = lsb_flag && (lsb_dest == tag);
        ready   = done_vec[tag] || alu_hit || lsb_hit;
        if (alu_hit) begin
            val = alu_val;
        end else if (lsb_hit) begin
            val = lsb_val;
        end else begin
            val = val_vec[tag];
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// Circular in-order retirement queue with dual write-back, single commit per
// cycle and branch resolution at commit (mispredict flushes everything).
module reorder_buffer
    import rob_pkg::*;
#(
    parameter int ROB_WIDTH = ROB_WIDTH_DEFAULT
) (
    input  logic                 clockIn,
    input  logic                 resetIn,
    input  logic                 readyIn,
    input  logic                 issueFlag,
    input  logic [1:0]           issueType,
    input  logic [4:0]           issueRd,
    input  logic                 issuePredTaken,
    input  logic [31:0]          issueAltPc,
    output logic [ROB_WIDTH-1:0] issueTag,
    output logic                 full,
    input  logic [ROB_WIDTH-1:0] qjTag,
    input  logic [ROB_WIDTH-1:0] qkTag,
    output logic                 qjReady,
    output logic                 qkReady,
    output logic [31:0]          qjVal,
    output logic [31:0]          qkVal,
    input  logic                 aluFlag,
    input  logic [31:0]          aluVal,
    input  logic [ROB_WIDTH-1:0] aluDest,
    input  logic                 lsbFlag,
    input  logic [31:0]          lsbVal,
    input  logic [ROB_WIDTH-1:0] lsbDest,
    output logic                 commitFlag,
    output logic [ROB_WIDTH-1:0] commitTag,
    output logic [4:0]           commitRd,
    output logic [31:0]          commitVal,
    output logic                 commitStore,
    output logic                 flushFlag,
    output logic [31:0]          flushPc
);

    localparam int ROB_SIZE = 1 << ROB_WIDTH;

    rob_entry_t           entries_q [ROB_SIZE];
    rob_entry_t           entries_d [ROB_SIZE];
    logic [ROB_WIDTH-1:0] head_q, head_d;
    logic [ROB_WIDTH-1:0] tail_q, tail_d;
    logic [ROB_WIDTH:0]   count_q, count_d;

    logic                 commit_flag_q, commit_flag_d;
    logic [ROB_WIDTH-1:0] commit_tag_q, commit_tag_d;
    logic [4:0]           commit_rd_q, commit_rd_d;
    logic [31:0]          commit_val_q, commit_val_d;
    logic                 commit_store_q, commit_store_d;
    logic                 flush_flag_q, flush_flag_d;
    logic [31:0]          flush_pc_q, flush_pc_d;

    rob_entry_t           head_entry;
    logic                 is_full;
    logic                 commit_fire;
    logic                 mispredict;
    logic                 issue_fire;

    logic [ROB_SIZE-1:0]        done_vec;
    logic [ROB_SIZE-1:0][31:0]  val_vec;

    always_comb begin
        head_entry  = entries_q[head_q];
        is_full     = (count_q == (ROB_WIDTH+1)'(ROB_SIZE));
        commit_fire = head_entry.busy && head_entry.done;
        mispredict  = commit_fire && (head_entry.itype == TYPE_BRANCH) &&
                      (head_entry.val[0] != head_entry.pred_taken);
        issue_fire  = issueFlag && !is_full;
    end

    always_comb begin
        for (int unsigned i = 0; i < ROB_SIZE; i++) begin
            done_vec[i] = entries_q[i].done;
            val_vec[i]  = entries_q[i].val;
        end
    end

    always_comb begin
        entries_d      = entries_q;
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        commit_flag_d  = 1'b0;
        commit_tag_d   = commit_tag_q;
        commit_rd_d    = commit_rd_q;
        commit_val_d   = commit_val_q;
        commit_store_d = commit_store_q;
        flush_flag_d   = 1'b0;
        flush_pc_d     = flush_pc_q;

        // LSB is applied first so a same-tag ALU write-back wins, matching lookup priority.
        if (lsbFlag && entries_q[lsbDest].busy) begin
            entries_d[lsbDest].done = 1'b1;
            entries_d[lsbDest].val  = lsbVal;
        end
        if (aluFlag && entries_q[aluDest].busy) begin
            entries_d[aluDest].done = 1'b1;
            entries_d[aluDest].val  = aluVal;
        end

        if (commit_fire) begin
            entries_d[head_q].busy = 1'b0;
            entries_d[head_q].done = 1'b0;
            head_d         = head_q + ROB_WIDTH'(1);
            commit_flag_d  = 1'b1;
            commit_tag_d   = head_q;
            commit_rd_d    = (head_entry.itype == TYPE_REG) ? head_entry.rd : '0;
            commit_val_d   = head_entry.val;
            commit_store_d = (head_entry.itype == TYPE_STORE);
        end

        if (issue_fire) begin
            entries_d[tail_q].busy       = 1'b1;
            entries_d[tail_q].done       = 1'b0;
            entries_d[tail_q].itype      = rob_type_e'(issueType);
            entries_d[tail_q].rd         = issueRd;
            entries_d[tail_q].pred_taken = issuePredTaken;
            entries_d[tail_q].alt_pc     = issueAltPc;
            entries_d[tail_q].val        = '0;
            tail_d = tail_q + ROB_WIDTH'(1);
        end

        case ({issue_fire, commit_fire})
            2'b10:   count_d = count_q + (ROB_WIDTH+1)'(1);
            2'b01:   count_d = count_q - (ROB_WIDTH+1)'(1);
            default: count_d = count_q;
        endcase

        if (mispredict) begin
            for (int unsigned i = 0; i < ROB_SIZE; i++) begin
                entries_d[i].busy = 1'b0;
                entries_d[i].done = 1'b0;
            end
            head_d       = '0;
            tail_d       = '0;
            count_d      = '0;
            flush_flag_d = 1'b1;
            flush_pc_d   = head_entry.alt_pc;
        end
    end

    always_ff @(posedge clockIn) begin
        if (resetIn) begin
            for (int unsigned i = 0; i < ROB_SIZE; i++) begin
                entries_q[i] <= '0;
            end
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            commit_flag_q  <= 1'b0;
            commit_tag_q   <= '0;
            commit_rd_q    <= '0;
            commit_val_q   <= '0;
            commit_store_q <= 1'b0;
            flush_flag_q   <= 1'b0;
            flush_pc_q     <= '0;
        end else if (readyIn) begin
            entries_q      <= entries_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            commit_flag_q  <= commit_flag_d;
            commit_tag_q   <= commit_tag_d;
            commit_rd_q    <= commit_rd_d;
            commit_val_q   <= commit_val_d;
            commit_store_q <= commit_store_d;
            flush_flag_q   <= flush_flag_d;
            flush_pc_q     <= flush_pc_d;
        end
    end

    rob_lookup #(.ROB_WIDTH(ROB_WIDTH)) u_lookup_j (
        .tag      (qjTag),
        .done_vec (done_vec),
        .val_vec  (val_vec),
        .alu_flag (aluFlag),
        .alu_val  (aluVal),
        .alu_dest (aluDest),
        .lsb_flag (lsbFlag),
        .lsb_val  (lsbVal),
        .lsb_dest (lsbDest),
        .ready    (qjReady),
        .val      (qjVal)
    );

    rob_lookup #(.ROB_WIDTH(ROB_WIDTH)) u_lookup_k (
        .tag      (qkTag),
        .done_vec (done_vec),
        .val_vec  (val_vec),
        .alu_flag (aluFlag),
        .alu_val  (aluVal),
        .alu_dest (aluDest),
        .lsb_flag (lsbFlag),
        .lsb_val  (lsbVal),
        .lsb_dest (lsbDest),
        .ready    (qkReady),
        .val      (qkVal)
    );

    assign issueTag    = tail_q;
    assign full        = is_full;
    assign commitFlag  = commit_flag_q;
    assign commitTag   = commit_tag_q;
    assign commitRd    = commit_rd_q;
    assign commitVal   = commit_val_q;
    assign commitStore = commit_store_q;
    assign flushFlag   = flush_flag_q;
    assign flushPc     = flush_pc_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: expected commits queued at issue, checked at commit.
module tb_reorder_buffer;
    import rob_pkg::*;

    logic        clockIn = 1'b0;
    logic        resetIn = 1'b1;
    logic        readyIn = 1'b1;
    logic        issueFlag = 1'b0;
    logic [1:0]  issueType = 2'b00;
    logic [4:0]  issueRd = '0;
    logic        issuePredTaken = 1'b0;
    logic [31:0] issueAltPc = '0;
    logic [3:0]  issueTag;
    logic        full;
    logic [3:0]  qjTag = '0;
    logic [3:0]  qkTag = '0;
    logic        qjReady, qkReady;
    logic [31:0] qjVal, qkVal;
    logic        aluFlag = 1'b0;
    logic [31:0] aluVal = '0;
    logic [3:0]  aluDest = '0;
    logic        lsbFlag = 1'b0;
    logic [31:0] lsbVal = '0;
    logic [3:0]  lsbDest = '0;
    logic        commitFlag;
    logic [3:0]  commitTag;
    logic [4:0]  commitRd;
    logic [31:0] commitVal;
    logic        commitStore;
    logic        flushFlag;
    logic [31:0] flushPc;

    always #5 clockIn = ~clockIn;

    reorder_buffer #(.ROB_WIDTH(4)) dut (
        .clockIn(clockIn), .resetIn(resetIn), .readyIn(readyIn),
        .issueFlag(issueFlag), .issueType(issueType), .issueRd(issueRd),
        .issuePredTaken(issuePredTaken), .issueAltPc(issueAltPc),
        .issueTag(issueTag), .full(full),
        .qjTag(qjTag), .qkTag(qkTag), .qjReady(qjReady), .qkReady(qkReady),
        .qjVal(qjVal), .qkVal(qkVal),
        .aluFlag(aluFlag), .aluVal(aluVal), .aluDest(aluDest),
        .lsbFlag(lsbFlag), .lsbVal(lsbVal), .lsbDest(lsbDest),
        .commitFlag(commitFlag), .commitTag(commitTag), .commitRd(commitRd),
        .commitVal(commitVal), .commitStore(commitStore),
        .flushFlag(flushFlag), .flushPc(flushPc)
    );

    typedef struct {
        logic [3:0]  tag;
        logic [4:0]  rd;
        logic [31:0] val;
        logic        store;
        logic        flush;
        logic [31:0] pc;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [3:0]  model_tail = '0;
    logic [31:0] plan_val [16];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
        end
    endtask

    // Commit monitor: sample 1ns after each edge at which the buffer was enabled.
    logic rdy_at_edge;
    exp_t mon_e;
    always @(posedge clockIn) begin
        rdy_at_edge = readyIn && !resetIn;
        #1;
        if (rdy_at_edge && commitFlag) begin
            if (sb.size() == 0) begin
                check("spurious_commit", 32'(commitTag), 32'hdead);
            end else begin
                mon_e = sb.pop_front();
                check("commit_tag", 32'(commitTag), 32'(mon_e.tag));
                check("commit_rd", 32'(commitRd), 32'(mon_e.rd));
                check("commit_val", commitVal, mon_e.val);
                check("commit_store", 32'(commitStore), 32'(mon_e.store));
                check("commit_flush", 32'(flushFlag), 32'(mon_e.flush));
                if (mon_e.flush) begin
                    check("flush_pc", flushPc, mon_e.pc);
                    sb.delete();
                end
            end
        end else if (rdy_at_edge) begin
            check("flush_idle", 32'(flushFlag), 32'd0);
        end
    end

    task automatic tick();
        @(negedge clockIn);
    endtask

    task automatic do_reset();
        resetIn   = 1'b1;
        readyIn   = 1'b1;
        issueFlag = 1'b0;
        aluFlag   = 1'b0;
        lsbFlag   = 1'b0;
        repeat (2) tick();
        resetIn    = 1'b0;
        sb.delete();
        model_tail = '0;
    endtask

    task automatic issue(input logic [1:0] t, input logic [4:0] rd, input logic pred,
                         input logic [31:0] alt, input logic [31:0] v);
        exp_t e;
        check("issue_tag", 32'(issueTag), 32'(model_tail));
        issueFlag      = 1'b1;
        issueType      = t;
        issueRd        = rd;
        issuePredTaken = pred;
        issueAltPc     = alt;
        e.tag   = model_tail;
        e.rd    = (t == TYPE_REG) ? rd : 5'd0;
        e.val   = v;
        e.store = (t == TYPE_STORE);
        e.flush = (t == TYPE_BRANCH) && (v[0] != pred);
        e.pc    = alt;
        sb.push_back(e);
        plan_val[model_tail] = v;
        model_tail = model_tail + 4'd1;
        tick();
        issueFlag = 1'b0;
    endtask

    task automatic wb(input logic use_alu, input logic [3:0] a_tag,
                      input logic use_lsb, input logic [3:0] l_tag);
        aluFlag = use_alu;
        aluDest = a_tag;
        aluVal  = plan_val[a_tag];
        lsbFlag = use_lsb;
        lsbDest = l_tag;
        lsbVal  = plan_val[l_tag];
        tick();
        aluFlag = 1'b0;
        lsbFlag = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 60 && sb.size() != 0; i++) tick();
        check(name, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        do_reset();
        check("rst_commitFlag", 32'(commitFlag), 32'd0);
        check("rst_flushFlag", 32'(flushFlag), 32'd0);
        check("rst_commitTag", 32'(commitTag), 32'd0);
        check("rst_commitRd", 32'(commitRd), 32'd0);
        check("rst_commitVal", commitVal, 32'd0);
        check("rst_commitStore", 32'(commitStore), 32'd0);
        check("rst_flushPc", flushPc, 32'd0);
        check("rst_issueTag", 32'(issueTag), 32'd0);
        check("rst_full", 32'(full), 32'd0);

        // Single issue / write-back / commit with exact latency
        issue(TYPE_REG, 5'd5, 1'b0, 32'd0, 32'h1234);
        wb(1'b1, 4'd0, 1'b0, 4'd0);
        check("commit_early", 32'(commitFlag), 32'd0);
        tick();
        check("t1_flag", 32'(commitFlag), 32'd1);
        check("t1_rd", 32'(commitRd), 32'd5);
        check("t1_val", commitVal, 32'h1234);
        check("t1_tag", 32'(commitTag), 32'd0);
        tick();
        check("commit_pulse", 32'(commitFlag), 32'd0);

        // Out-of-order write-back, in-order consecutive commit
        issue(TYPE_REG, 5'd10, 1'b0, 32'd0, 32'h0a0a);
        issue(TYPE_REG, 5'd11, 1'b0, 32'd0, 32'h0b0b);
        issue(TYPE_REG, 5'd12, 1'b0, 32'd0, 32'h0c0c);
        wb(1'b1, 4'd3, 1'b0, 4'd0);
        wb(1'b0, 4'd0, 1'b1, 4'd2);
        wb(1'b1, 4'd1, 1'b0, 4'd0);
        tick();
        check("t2_c0", 32'(commitTag), 32'd1);
        tick();
        check("t2_c1", 32'(commitTag), 32'd2);
        tick();
        check("t2_c2", 32'(commitTag), 32'd3);
        wait_drain("t2_drain");

        // Fill, ignore 17th issue, retire head, wrap tail
        do_reset();
        for (int i = 0; i < 16; i++) begin
            if (i == 7)
                issue(TYPE_BRANCH, 5'(i + 1), 1'b1, 32'h200 + i, 32'h1);
            else if (i % 4 == 1)
                issue(TYPE_STORE, 5'(i + 1), 1'b0, 32'h200 + i, 32'ha000 + i);
            else
                issue(TYPE_REG, 5'(i + 1), 1'b0, 32'h200 + i, 32'ha000 + i);
        end
        check("full_set", 32'(full), 32'd1);
        issueFlag = 1'b1;
        issueType = TYPE_REG;
        tick();
        issueFlag = 1'b0;
        check("full_tag_hold", 32'(issueTag), 32'd0);
        check("full_still", 32'(full), 32'd1);
        wb(1'b1, 4'd0, 1'b0, 4'd0);
        tick();
        check("full_clear", 32'(full), 32'd0);
        issue(TYPE_REG, 5'd9, 1'b0, 32'd0, 32'hbeef);
        for (int i = 1; i < 15; i += 2) wb(1'b1, 4'(i), 1'b1, 4'(i + 1));
        wb(1'b1, 4'd15, 1'b1, 4'd0);
        wait_drain("t3_drain");

        // Mispredicted branch flushes, same-cycle issue dropped
        do_reset();
        issue(TYPE_REG, 5'd3, 1'b0, 32'd0, 32'h55);
        issue(TYPE_BRANCH, 5'd0, 1'b1, 32'h100, 32'h0);
        issue(TYPE_REG, 5'd4, 1'b0, 32'd0, 32'h66);
        wb(1'b1, 4'd2, 1'b1, 4'd0);
        wb(1'b1, 4'd1, 1'b0, 4'd0);
        issueFlag = 1'b1;
        issueType = TYPE_REG;
        issueRd   = 5'd7;
        tick();
        issueFlag = 1'b0;
        check("t4_flush", 32'(flushFlag), 32'd1);
        check("t4_flushpc", flushPc, 32'h100);
        check("t4_tag_reset", 32'(issueTag), 32'd0);
        check("t4_full", 32'(full), 32'd0);
        model_tail = '0;
        qjTag = 4'd2;
        tick();
        check("t4_flush_pulse", 32'(flushFlag), 32'd0);
        check("t4_cleared", 32'(qjReady), 32'd0);
        issue(TYPE_REG, 5'd8, 1'b0, 32'd0, 32'h77);
        wb(1'b1, 4'd0, 1'b0, 4'd0);
        wait_drain("t4_drain");

        // Combinational lookup with write-back bypass
        do_reset();
        issue(TYPE_REG, 5'd1, 1'b0, 32'd0, 32'haaaa);
        issue(TYPE_REG, 5'd2, 1'b0, 32'd0, 32'h11);
        issue(TYPE_REG, 5'd3, 1'b0, 32'd0, 32'h9);
        issue(TYPE_REG, 5'd4, 1'b0, 32'd0, 32'h7);
        qjTag = 4'd3;
        qkTag = 4'd2;
        #1;
        check("lk_not_ready", 32'(qjReady), 32'd0);
        aluFlag = 1'b1; aluDest = 4'd3; aluVal = 32'h7;
        lsbFlag = 1'b1; lsbDest = 4'd2; lsbVal = 32'h9;
        #1;
        check("lk_j_ready", 32'(qjReady), 32'd1);
        check("lk_j_val", qjVal, 32'h7);
        check("lk_k_ready", 32'(qkReady), 32'd1);
        check("lk_k_val", qkVal, 32'h9);
        tick();
        qjTag = 4'd0;
        qkTag = 4'd1;
        aluFlag = 1'b1; aluDest = 4'd0; aluVal = 32'haaaa;
        lsbFlag = 1'b1; lsbDest = 4'd0; lsbVal = 32'hbbbb;
        #1;
        check("lk_alu_prio", qjVal, 32'haaaa);
        check("lk_k_idle", 32'(qkReady), 32'd0);
        tick();
        aluFlag = 1'b0;
        lsbFlag = 1'b0;
        qkTag = 4'd3;
        #1;
        check("lk_stored_ready", 32'(qjReady), 32'd1);
        check("lk_stored_val", qjVal, 32'haaaa);
        check("lk_stored_k", qkVal, 32'h7);
        wb(1'b1, 4'd1, 1'b0, 4'd0);
        wait_drain("t5_drain");

        // readyIn low holds state and registered outputs
        do_reset();
        issue(TYPE_REG, 5'd6, 1'b0, 32'd0, 32'h42);
        issue(TYPE_REG, 5'd7, 1'b0, 32'd0, 32'h43);
        wb(1'b1, 4'd0, 1'b0, 4'd0);
        tick();
        check("t6_commit", 32'(commitFlag), 32'd1);
        readyIn   = 1'b0;
        aluFlag   = 1'b1; aluDest = 4'd1; aluVal = 32'h43;
        issueFlag = 1'b1;
        qjTag     = 4'd1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_flag", 32'(commitFlag), 32'd1);
            check("hold_tag", 32'(commitTag), 32'd0);
            check("hold_val", commitVal, 32'h42);
            check("hold_issuetag", 32'(issueTag), 32'd2);
        end
        aluFlag   = 1'b0;
        issueFlag = 1'b0;
        readyIn   = 1'b1;
        tick();
        check("hold_release", 32'(commitFlag), 32'd0);
        check("hold_no_issue", 32'(issueTag), 32'd2);
        check("hold_no_wb", 32'(qjReady), 32'd0);
        wb(1'b1, 4'd1, 1'b0, 4'd0);
        wait_drain("t6_drain");

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
